scan_ckpt_ctrl: RTL and testbench

Hardware checkpoint sequencer for the emulation system. It automates the save/restore protocol that the simulation benches drive by hand. On a host command or a periodic auto-trigger it pauses the target, resets the RAM scan pointer, then streams a 64-bit cycle counter, the FF scan chain and the RAM scan chain out to a save stream or in from a restore stream, with full valid/ready backpressure. It sits between `EMU_SYSTEM`'s scan ports and the host DMA/stream interface.

---
 rtl/scan_ckpt_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_scan_ckpt_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_ckpt_ctrl.sv
// Checkpoint sequencer: pauses the target and streams the cycle counter, the FF scan
// chain and the RAM scan chain out to a save stream or in from a restore stream.
module scan_ckpt_ctrl #(
    parameter int DATA_WIDTH   = 64,
    parameter int FF_WORDS     = 16,
    parameter int MEM_WORDS    = 64,
    parameter int PERIOD_WIDTH = 32
) (
    input  logic                    host_clk,
    input  logic                    host_rst,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_dir,
    input  logic [PERIOD_WIDTH-1:0] auto_period,

    output logic                    run_mode,
    output logic                    scan_mode,

    output logic                    ff_se,
    output logic                    ff_sd,
    output logic [DATA_WIDTH-1:0]   ff_di,
    input  logic [DATA_WIDTH-1:0]   ff_do,

    output logic                    ram_sr,
    output logic                    ram_se,
    output logic                    ram_sd,
    output logic [DATA_WIDTH-1:0]   ram_di,
    input  logic [DATA_WIDTH-1:0]   ram_do,

    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DATA_WIDTH-1:0]   m_data,
    output logic                    m_last,

    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_WIDTH-1:0]   s_data,

    output logic [63:0]             cycle,
    output logic                    busy,
    output logic                    done
);

    localparam int MAX_WORDS = (FF_WORDS > MEM_WORDS) ? FF_WORDS : MEM_WORDS;
    localparam int WCNT_W    = $clog2(MAX_WORDS + 1);

    localparam logic [WCNT_W-1:0] FF_LAST  = WCNT_W'(FF_WORDS - 1);
    localparam logic [WCNT_W-1:0] MEM_LAST = WCNT_W'(MEM_WORDS - 1);
    localparam logic [WCNT_W-1:0] GAP_LAST = WCNT_W'(1);

    typedef enum logic [3:0] {
        S_RUN,
        S_PAUSE,
        S_SCAN_ON,
        S_CYC,
        S_FF,
        S_MEM_GAP,
        S_MEM,
        S_DRAIN,
        S_SCAN_OFF
    } state_t;

    state_t                  state, state_nxt;
    logic                    dir, dir_nxt;
    logic [WCNT_W-1:0]       wcnt, wcnt_nxt;
    logic [PERIOD_WIDTH-1:0] auto_cnt;

    logic auto_fire;
    logic xfer;
    logic load_cycle;

    // Counter can sit above a freshly lowered period, so the compare is >= rather than ==.
    assign auto_fire = (auto_period != '0) && (auto_cnt >= (auto_period - PERIOD_WIDTH'(1)));

    // One beat per cycle at most; its direction selects which side of the stream handshakes.
    assign xfer = dir ? s_valid : m_ready;

    assign busy = (state != S_RUN);

    always_comb begin
        state_nxt  = state;
        dir_nxt    = dir;
        wcnt_nxt   = wcnt;
        load_cycle = 1'b0;

        cmd_ready  = 1'b0;
        run_mode   = 1'b0;
        scan_mode  = 1'b0;
        ff_se      = 1'b0;
        ff_sd      = 1'b0;
        ff_di      = '0;
        ram_sr     = 1'b0;
        ram_se     = 1'b0;
        ram_sd     = 1'b0;
        ram_di     = '0;
        m_valid    = 1'b0;
        m_data     = '0;
        m_last     = 1'b0;
        s_ready    = 1'b0;
        done       = 1'b0;

        case (state)
            S_RUN: begin
                run_mode  = 1'b1;
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    dir_nxt   = cmd_dir;
                    state_nxt = S_PAUSE;
                end else if (auto_fire) begin
                    dir_nxt   = 1'b0;
                    state_nxt = S_PAUSE;
                end
            end

            S_PAUSE: begin
                state_nxt = S_SCAN_ON;
            end

            S_SCAN_ON: begin
                scan_mode = 1'b1;
                ram_sr    = 1'b1;
                wcnt_nxt  = '0;
                state_nxt = S_CYC;
            end

            S_CYC: begin
                scan_mode = 1'b1;
                if (dir) begin
                    s_ready = 1'b1;
                end else begin
                    m_valid = 1'b1;
                    m_data  = DATA_WIDTH'(cycle);
                end
                if (xfer) begin
                    load_cycle = dir;
                    state_nxt  = S_FF;
                end
            end

            S_FF: begin
                scan_mode = 1'b1;
                ff_sd     = dir;
                ff_se     = xfer;
                if (dir) begin
                    s_ready = 1'b1;
                    ff_di   = s_data;
                end else begin
                    m_valid = 1'b1;
                    m_data  = ff_do;
                end
                if (xfer) begin
                    if (wcnt == FF_LAST) begin
                        wcnt_nxt  = '0;
                        state_nxt = dir ? S_MEM : S_MEM_GAP;
                    end else begin
                        wcnt_nxt = wcnt + WCNT_W'(1);
                    end
                end
            end

            // Two read shifts fill the RAM read pipeline before the first save beat.
            S_MEM_GAP: begin
                scan_mode = 1'b1;
                ram_se    = 1'b1;
                if (wcnt == GAP_LAST) begin
                    wcnt_nxt  = '0;
                    state_nxt = S_MEM;
                end else begin
                    wcnt_nxt = wcnt + WCNT_W'(1);
                end
            end

            S_MEM: begin
                scan_mode = 1'b1;
                ram_sd    = dir;
                ram_se    = xfer;
                if (dir) begin
                    s_ready = 1'b1;
                    ram_di  = s_data;
                end else begin
                    m_valid = 1'b1;
                    m_data  = ram_do;
                    m_last  = (wcnt == MEM_LAST);
                end
                if (xfer) begin
                    if (wcnt == MEM_LAST) begin
                        wcnt_nxt  = '0;
                        state_nxt = S_DRAIN;
                    end else begin
                        wcnt_nxt = wcnt + WCNT_W'(1);
                    end
                end
            end

            // Idle scan cycle lets the last RAM write land before scan is dropped.
            S_DRAIN: begin
                scan_mode = 1'b1;
                state_nxt = S_SCAN_OFF;
            end

            S_SCAN_OFF: begin
                done      = 1'b1;
                state_nxt = S_RUN;
            end

            default: begin
                state_nxt = S_RUN;
            end
        endcase
    end

    always_ff @(posedge host_clk) begin
        if (host_rst) begin
            state <= S_RUN;
            dir   <= 1'b0;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            dir   <= dir_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    always_ff @(posedge host_clk) begin
        if (host_rst) begin
            cycle    <= '0;
            auto_cnt <= '0;
        end else begin
            if (run_mode) begin
                cycle <= cycle + 64'd1;
            end else if (load_cycle) begin
                cycle <= s_data[63:0];
            end

            if (state != S_RUN) begin
                auto_cnt <= '0;
            end else if (auto_cnt != '1) begin
                auto_cnt <= auto_cnt + PERIOD_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_scan_ckpt_ctrl.sv
// Scoreboard bench for scan_ckpt_ctrl with a behavioural target (FF chain + RAM chain).
module tb_scan_ckpt_ctrl;

    localparam int DW  = 64;
    localparam int FFW = 4;
    localparam int MW  = 8;
    localparam int PW  = 32;

    logic           host_clk = 1'b0;
    logic           host_rst;
    logic           cmd_valid, cmd_ready, cmd_dir;
    logic [PW-1:0]  auto_period;
    logic           run_mode, scan_mode;
    logic           ff_se, ff_sd;
    logic [DW-1:0]  ff_di, ff_do;
    logic           ram_sr, ram_se, ram_sd;
    logic [DW-1:0]  ram_di, ram_do;
    logic           m_valid, m_ready, m_last;
    logic [DW-1:0]  m_data;
    logic           s_valid, s_ready;
    logic [DW-1:0]  s_data;
    logic [63:0]    cycle;
    logic           busy, done;

    always #5 host_clk = ~host_clk;

    scan_ckpt_ctrl #(
        .DATA_WIDTH(DW), .FF_WORDS(FFW), .MEM_WORDS(MW), .PERIOD_WIDTH(PW)
    ) dut (
        .host_clk(host_clk), .host_rst(host_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .auto_period(auto_period),
        .run_mode(run_mode), .scan_mode(scan_mode),
        .ff_se(ff_se), .ff_sd(ff_sd), .ff_di(ff_di), .ff_do(ff_do),
        .ram_sr(ram_sr), .ram_se(ram_se), .ram_sd(ram_sd), .ram_di(ram_di), .ram_do(ram_do),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .cycle(cycle), .busy(busy), .done(done)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] s_q[$];
    bit            m_rand = 1'b0;
    bit            s_rand = 1'b0;
    logic [1:0]    tgt_cmd = 2'd0;

    function automatic logic [DW-1:0] ff_val(input int i);
        return 64'hF0F0_0000_0000_0000 + 64'(i);
    endfunction

    function automatic logic [DW-1:0] mem_val(input int i);
        return 64'hA5A5_0000_0000_1000 + 64'(i * 3);
    endfunction

    // Target: FF chain recirculates on save, shifts in on restore; RAM reads through a 2-deep pipe.
    logic [DW-1:0] ff_chain [FFW];
    logic [DW-1:0] mem      [MW];
    logic [DW-1:0] rd1, rd2;
    int            ptr;

    always @(posedge host_clk) begin
        if (tgt_cmd != 2'd0) begin
            for (int i = 0; i < FFW; i++)
                ff_chain[i] <= (tgt_cmd == 2'd1) ? ff_val(i) : 64'hDEAD_0000_0000_0000 + 64'(i);
            for (int i = 0; i < MW; i++)
                mem[i] <= (tgt_cmd == 2'd1) ? mem_val(i) : 64'hBEEF_0000_0000_0000 + 64'(i);
            rd1 <= '0;
            rd2 <= '0;
            ptr <= 0;
        end else begin
            if (ff_se) begin
                for (int i = 0; i < FFW - 1; i++) ff_chain[i] <= ff_chain[i+1];
                ff_chain[FFW-1] <= ff_sd ? ff_di : ff_chain[0];
            end
            if (ram_sr) begin
                ptr <= 0;
            end else if (ram_se) begin
                if (ram_sd) begin
                    mem[ptr] <= ram_di;
                end else begin
                    rd1 <= mem[ptr];
                    rd2 <= rd1;
                end
                ptr <= (ptr + 1) % MW;
            end
        end
    end

    assign ff_do  = ff_chain[0];
    assign ram_do = rd2;

    int rl_cnt = 0, done_cnt = 0, ffse_cnt = 0, ramse_cnt = 0;
    always @(negedge host_clk) begin
        rl_cnt    <= rl_cnt + (run_mode ? 0 : 1);
        done_cnt  <= done_cnt + (done ? 1 : 0);
        ffse_cnt  <= ffse_cnt + (ff_se ? 1 : 0);
        ramse_cnt <= ramse_cnt + (ram_se ? 1 : 0);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Save-stream sink.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge host_clk);
            #1;
            m_ready = m_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Restore-stream source.
    initial begin
        bit fire;
        s_valid = 1'b0;
        s_data  = '0;
        forever begin
            @(negedge host_clk);
            fire = (s_valid === 1'b1) && (s_ready === 1'b1);
            @(posedge host_clk);
            if (fire && s_q.size() > 0) void'(s_q.pop_front());
            #1;
            if (s_q.size() > 0 && (!s_rand || $urandom_range(0, 1) == 1)) begin
                s_valid = 1'b1;
                s_data  = s_q[0];
            end else begin
                s_valid = 1'b0;
                s_data  = '0;
            end
        end
    end

    // Monitor: every save-stream beat is checked against the scoreboard.
    initial begin
        beat_t e;
        forever begin
            @(negedge host_clk);
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_beat: got data %0h, required no beat", m_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", m_data, e.data);
                    chk("beat_last", 64'(m_last), 64'(e.last));
                end
            end
        end
    end

    task automatic push_save(input logic [63:0] c);
        exp_q.push_back('{last: 1'b0, data: c});
        for (int i = 0; i < FFW; i++) exp_q.push_back('{last: 1'b0, data: ff_val(i)});
        for (int i = 0; i < MW; i++)  exp_q.push_back('{last: (i == MW - 1), data: mem_val(i)});
    endtask

    task automatic push_restore(input logic [63:0] c);
        s_q.push_back(c);
        for (int i = 0; i < FFW; i++) s_q.push_back(ff_val(i));
        for (int i = 0; i < MW; i++)  s_q.push_back(mem_val(i));
    endtask

    task automatic do_reset();
        @(posedge host_clk);
        #1 host_rst = 1'b1;
        @(posedge host_clk);
        #1 host_rst = 1'b0;
    endtask

    task automatic run_edges(input int n);
        repeat (n) @(posedge host_clk);
        #1;
    endtask

    task automatic issue(input logic d);
        cmd_valid = 1'b1;
        cmd_dir   = d;
        @(posedge host_clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge host_clk);
            seen = (done === 1'b1);
        end
        chk(name, 64'(seen), 64'd1);
    endtask

    task automatic settle();
        repeat (3) @(negedge host_clk);
        #1;
    endtask

    int rl0, dn0, ff0, rs0;

    task automatic snap();
        rl0 = rl_cnt; dn0 = done_cnt; ff0 = ffse_cnt; rs0 = ramse_cnt;
    endtask

    initial begin
        host_rst    = 1'b0;
        cmd_valid   = 1'b0;
        cmd_dir     = 1'b0;
        auto_period = '0;

        // Reset state
        tgt_cmd = 2'd1;
        do_reset();
        tgt_cmd = 2'd0;
        @(negedge host_clk);
        chk("rst_run_mode",  64'(run_mode),  64'd1);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_scan_mode", 64'(scan_mode), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_done",      64'(done),      64'd0);
        chk("rst_m_valid",   64'(m_valid),   64'd0);
        chk("rst_s_ready",   64'(s_ready),   64'd0);
        chk("rst_ram_sr",    64'(ram_sr),    64'd0);
        chk("rst_cycle",     cycle,          64'd0);

        // Save at cycle 500, no backpressure
        run_edges(499);
        push_save(64'd500);
        snap();
        issue(1'b0);
        wait_done("t1_done", 200);
        settle();
        chk("t1_run_low_cycles", 64'(rl_cnt - rl0),    64'd19);
        chk("t1_done_pulses",    64'(done_cnt - dn0),  64'd1);
        chk("t1_ff_shifts",      64'(ffse_cnt - ff0),  64'd4);
        chk("t1_ram_shifts",     64'(ramse_cnt - rs0), 64'd10);
        chk("t1_queue_empty",    64'(exp_q.size()),    64'd0);

        // Same save with random m_ready
        m_rand = 1'b1;
        do_reset();
        run_edges(499);
        push_save(64'd500);
        snap();
        issue(1'b0);
        wait_done("t2_done", 600);
        settle();
        chk("t2_ff_shifts",   64'(ffse_cnt - ff0),  64'd4);
        chk("t2_ram_shifts",  64'(ramse_cnt - rs0), 64'd10);
        chk("t2_done_pulses", 64'(done_cnt - dn0),  64'd1);
        chk("t2_queue_empty", 64'(exp_q.size()),    64'd0);

        // Scramble target, restore at cycle 900, save again
        s_rand  = 1'b1;
        tgt_cmd = 2'd2;
        do_reset();
        tgt_cmd = 2'd0;
        push_restore(64'd500);
        run_edges(899);
        issue(1'b1);
        wait_done("t3_restore_done", 600);
        @(posedge host_clk);
        #1;
        chk("t3_cycle_restored", cycle, 64'd500);
        chk("t3_stream_drained", 64'(s_q.size()), 64'd0);
        push_save(64'd501);
        issue(1'b0);
        wait_done("t3_save_done", 600);
        settle();
        chk("t3_queue_empty", 64'(exp_q.size()), 64'd0);
        s_rand = 1'b0;
        m_rand = 1'b0;

        // Periodic auto save every 100 run cycles
        do_reset();
        auto_period = 32'd100;
        push_save(64'd100);
        push_save(64'd200);
        push_save(64'd300);
        wait_done("t4_auto1_done", 300);
        wait_done("t4_auto2_done", 300);
        wait_done("t4_auto3_done", 300);
        auto_period = '0;
        settle();
        chk("t4_queue_empty", 64'(exp_q.size()), 64'd0);

        // Restore command coinciding with the auto trigger
        do_reset();
        auto_period = 32'd100;
        push_restore(64'd500);
        run_edges(99);
        snap();
        issue(1'b1);
        wait_done("t5_restore_done", 100);
        settle();
        chk("t5_run_low_cycles", 64'(rl_cnt - rl0), 64'd17);
        chk("t5_stream_drained", 64'(s_q.size()),   64'd0);
        push_save(64'd600);
        wait_done("t5_auto_done", 300);
        auto_period = '0;
        settle();
        chk("t5_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset during the second FF beat
        do_reset();
        run_edges(499);
        exp_q.push_back('{last: 1'b0, data: 64'd500});
        exp_q.push_back('{last: 1'b0, data: ff_val(0)});
        exp_q.push_back('{last: 1'b0, data: ff_val(1)});
        issue(1'b0);
        repeat (4) @(posedge host_clk);
        #1 host_rst = 1'b1;
        @(posedge host_clk);
        #1 host_rst = 1'b0;
        @(negedge host_clk);
        chk("t6_run_mode",  64'(run_mode),  64'd1);
        chk("t6_scan_mode", 64'(scan_mode), 64'd0);
        chk("t6_busy",      64'(busy),      64'd0);
        chk("t6_cycle",     cycle,          64'd0);
        repeat (20) @(negedge host_clk);
        #1;
        chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
